// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: canonical hex glyph table,
// segment bit positions and a width helper.
package seg7_pkg;

    // Bit positions of each segment inside a 7-bit {A,B,C,D,E,F,G} code.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-low glyphs for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder with selectable pin polarity.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
)
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    logic [6:0] code;

    always_comb begin
        code  = SEG_TABLE[nibble_i];
        seg_o = {code[SEG_A], code[SEG_B], code[SEG_C], code[SEG_D],
                 code[SEG_E], code[SEG_F], code[SEG_G]};
        if (!ACTIVE_LOW) begin
            seg_o = ~seg_o;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment driver: slot prescaler, blanking,
// PWM dimming, frame-latched display data and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int PRESCALE       = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int BRIGHT_W       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS)
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_tick
);

    localparam int SLOT_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_wrap, frame_wrap, shadow_load, on_phase;
    logic                    pwm_lit, lit, above;
    logic [4*NUM_DIGITS-1:0] cur_digits;
    logic [NUM_DIGITS-1:0]   cur_dp, cur_en, suppressed, sel;
    logic [3:0]              cur_nib;
    logic                    cur_dp_bit, cur_en_bit, cur_supp;
    logic [6:0]              dec_seg;

    // Counters: everything freezes while en is low.
    always_comb begin
        // NOTE: every comb output gets a default before any branch so no latch is inferred.
        slot_cnt_d  = slot_cnt_q;
        scan_idx_d  = scan_idx_q;
        pwm_cnt_d   = pwm_cnt_q;
        slot_wrap   = (slot_cnt_q == SLOT_W'(PRESCALE - 1));
        frame_wrap  = slot_wrap && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));
        shadow_load = en && (slot_cnt_q == '0) && (scan_idx_q == '0);
        on_phase    = (slot_cnt_q >= SLOT_W'(BLANK_CYCLES));
        if (en) begin
            slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
            if (slot_wrap) begin
                scan_idx_d = frame_wrap ? '0 : scan_idx_q + IDX_W'(1);
            end
            // The first ON cycle of a slot always starts the PWM period at 0.
            pwm_cnt_d = (slot_cnt_d <= SLOT_W'(BLANK_CYCLES)) ? '0 : pwm_cnt_q + BRIGHT_W'(1);
        end
    end

    // On the load cycle the fresh inputs are used directly so the frame is consistent from cycle 0.
    always_comb begin
        cur_digits = shadow_load ? digits   : sh_digits_q;
        cur_dp     = shadow_load ? dp       : sh_dp_q;
        cur_en     = shadow_load ? digit_en : sh_en_q;

        suppressed = '0;
        above      = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            suppressed[i] = above && (cur_digits[4*i +: 4] == 4'h0) && !cur_dp[i];
            above         = suppressed[i];
        end

        cur_nib    = '0;
        cur_dp_bit = 1'b0;
        cur_en_bit = 1'b0;
        cur_supp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_nib    = cur_digits[4*i +: 4];
                cur_dp_bit = cur_dp[i];
                cur_en_bit = cur_en[i];
                cur_supp   = suppressed[i];
            end
        end
    end

    seg7_hex_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
    ) u_decode (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        pwm_lit = (pwm_cnt_q < brightness) || (brightness == '1);
        lit     = en && on_phase && cur_en_bit && !cur_supp && pwm_lit;
        sel     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (scan_idx_q == IDX_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
        an_d         = AN_OFF ^ sel;
        seg_d        = lit ? dec_seg : SEG_OFF;
        dp_out_d     = DP_OFF ^ (lit && cur_dp_bit);
        frame_tick_d = en && frame_wrap;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_q   <= '0;
            scan_idx_q   <= '0;
            pwm_cnt_q    <= '0;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            scan_idx_q   <= scan_idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            if (shadow_load) begin
                sh_digits_q <= digits;
                sh_dp_q     <= dp;
                sh_en_q     <= digit_en;
            end
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign scan_idx   = scan_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles,
// 2-bit brightness, active-low pins; expected pin states are queued per clock edge.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;

    // Lit pattern over the 8 cycles of a slot, bit c = slot cycle c.
    localparam logic [7:0] FULL = 8'b1111_1100;
    localparam logic [7:0] B1   = 8'b0100_0100;
    localparam logic [7:0] B2   = 8'b1100_1100;
    localparam logic [7:0] DARK = 8'b0000_0000;

    typedef struct {
        int          due;
        int          fr;
        logic [14:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt;
    int   slot_base;
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .PRESCALE       (8),
        .BLANK_CYCLES   (2),
        .BRIGHT_W       (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .digits      (digits),
        .dp          (dp),
        .digit_en    (digit_en),
        .lz_suppress (lz),
        .brightness  (brightness),
        .seg         (seg),
        .dp_out      (dp_out),
        .an          (an),
        .scan_idx    (scan_idx),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, wanted %h", name, act, req);
        end
    endtask

    // Entry value layout: {an[3:0], seg[6:0], dp_out, scan_idx[1:0], frame_tick}.
    task automatic push_entry(input int fr, input logic [3:0] an_v, input logic [6:0] seg_v,
                              input logic dp_v, input logic [1:0] idx_v, input logic tick_v);
        exp_t e;
        e.due = slot_base;
        e.fr  = fr;
        e.v   = {an_v, seg_v, dp_v, idx_v, tick_v};
        exp_q.push_back(e);
        slot_base++;
    endtask

    task automatic push_slot(input int fr, input int idx, input logic [7:0] mask,
                             input logic [6:0] seg_v, input logic dp_v,
                             input int pause_at, input int pause_len);
        logic [3:0] sel;
        sel = ~(4'b0001 << idx);
        for (int c = 0; c < 8; c++) begin
            if (c == pause_at) begin
                for (int k = 0; k < pause_len; k++)
                    push_entry(fr, 4'b1111, 7'h7f, 1'b1, 2'(idx), 1'b0);
            end
            if (mask[c])
                push_entry(fr, sel, seg_v, ~dp_v, 2'((c == 7) ? idx + 1 : idx), (c == 7) && (idx == 3));
            else
                push_entry(fr, 4'b1111, 7'h7f, 1'b1, 2'((c == 7) ? idx + 1 : idx), (c == 7) && (idx == 3));
        end
    endtask

    // segs = {s3,s2,s1,s0}, masks = {m3,m2,m1,m0}, dps = {d3,d2,d1,d0}.
    task automatic push_frame(input int fr, input logic [27:0] segs, input logic [31:0] masks,
                              input logic [3:0] dps);
        for (int i = 0; i < 4; i++)
            push_slot(fr, i, masks[8*i +: 8], segs[7*i +: 7], dps[i], 0, 0);
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (edge_cnt != n) check($sformatf("wait_edge%0d", n), edge_cnt, n);
    endtask

    // Monitor: compares every queued entry at the falling edge following its due rising edge.
    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                mon_e = exp_q.pop_front();
                if (mon_e.due < edge_cnt)
                    check($sformatf("missed_f%0d_e%0d", mon_e.fr, mon_e.due), edge_cnt, mon_e.due);
                else
                    check($sformatf("f%0d_e%0d", mon_e.fr, mon_e.due),
                          {17'd0, an, seg, dp_out, scan_idx, frame_tick}, {17'd0, mon_e.v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        reset = 1'b0; en = 1'b0; digits = '0; dp = '0; digit_en = '0; lz = 1'b0; brightness = '0;
        slot_base = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'h7f);
        check("rst_dp", dp_out, 1'b1);
        check("rst_idx", scan_idx, 2'd0);
        check("rst_tick", frame_tick, 1'b0);

        // Frame 0: plain 1234 at full brightness.
        en = 1'b1; digits = 16'h1234; digit_en = 4'hF; brightness = 2'd3;
        @(negedge clk);
        reset = 1'b1;
        push_frame(0, {S1, S2, S3, S4}, {4{FULL}}, 4'b0000);

        wait_edge(32);
        lz = 1'b1; digits = 16'h0050;
        push_frame(1, {S0, S0, S5, S0}, {DARK, DARK, FULL, FULL}, 4'b0000);

        wait_edge(64);
        digits = 16'h0000;
        push_frame(2, {S0, S0, S0, S0}, {DARK, DARK, DARK, FULL}, 4'b0000);

        wait_edge(96);
        dp = 4'b0100;
        push_frame(3, {S0, S0, S0, S0}, {DARK, FULL, FULL, FULL}, 4'b0100);

        wait_edge(128);
        dp = 4'b0000; lz = 1'b0; digits = 16'h4321; brightness = 2'd1;
        push_frame(4, {S4, S3, S2, S1}, {4{B1}}, 4'b0000);

        wait_edge(160);
        brightness = 2'd0;
        push_frame(5, {S4, S3, S2, S1}, {4{DARK}}, 4'b0000);

        wait_edge(192);
        brightness = 2'd2; digits = 16'h1111; digit_en = 4'b0101;
        push_frame(6, {4{S1}}, {DARK, B2, DARK, B2}, 4'b0000);

        // Frames 7-8: data changes during slot 2 but is only shown from the next frame.
        wait_edge(224);
        brightness = 2'd3; digit_en = 4'hF;
        push_frame(7, {4{S1}}, {4{FULL}}, 4'b0000);
        wait_edge(244);
        digits = 16'h2222;
        push_frame(8, {4{S2}}, {4{FULL}}, 4'b0000);

        // Frame 9: en low for 5 cycles from slot 1, cycle 4.
        wait_edge(288);
        push_slot(9, 0, FULL, S2, 1'b0, 0, 0);
        push_slot(9, 1, FULL, S2, 1'b0, 4, 5);
        push_slot(9, 2, FULL, S2, 1'b0, 0, 0);
        push_slot(9, 3, FULL, S2, 1'b0, 0, 0);
        wait_edge(300);
        en = 1'b0;
        wait_edge(305);
        en = 1'b1;

        // Frame 10: two slots, then reset in the middle of digit 2's ON phase.
        push_slot(10, 0, FULL, S2, 1'b0, 0, 0);
        push_slot(10, 1, FULL, S2, 1'b0, 0, 0);
        wait_edge(346);
        check("pre_reset_an", an, 4'b1011);
        reset = 1'b0;
        #1;
        check("midrst_an", an, 4'b1111);
        check("midrst_seg", seg, 7'h7f);
        check("midrst_dp", dp_out, 1'b1);
        check("midrst_idx", scan_idx, 2'd0);
        check("midrst_tick", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        slot_base = 1;
        reset = 1'b1;
        push_frame(11, {4{S2}}, {4{FULL}}, 4'b0000);

        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
